// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - image SRAM arbiter for flash loader, Z80 bus and diagnostics, with mirror windows
// Optional feature macro: RAM_WRITE_PROTECT_EN (read-only windows block CPU writes)
module ram_bus_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGIONS = 4,
    parameter int WAIT_CYCLES = 2,
    localparam int RW = $clog2(NUM_REGIONS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_done,
    input  logic [ADDR_WIDTH-1:0] flash_addr,
    input  logic [DATA_WIDTH-1:0] flash_wdata,
    input  logic                  flash_cs,
    input  logic                  flash_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_mreq_n,
    input  logic                  cpu_rd_n,
    input  logic                  cpu_wr_n,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_data_oe,
    output logic                  cpu_wait_n,
    input  logic                  diag_halt_req,
    output logic                  diag_halt_ack,
    input  logic                  diag_req,
    input  logic                  diag_we,
    input  logic [ADDR_WIDTH-1:0] diag_addr,
    input  logic [DATA_WIDTH-1:0] diag_wdata,
    output logic [DATA_WIDTH-1:0] diag_rdata,
    output logic                  diag_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  win_wr,
    input  logic [RW-1:0]         win_sel,
    input  logic [ADDR_WIDTH-1:0] win_start,
    input  logic [ADDR_WIDTH-1:0] win_end,
    input  logic                  win_ro,
    output logic                  mirror_we,
    output logic [RW-1:0]         mirror_idx,
    output logic [ADDR_WIDTH-1:0] mirror_offset
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_LOAD, S_IDLE, S_CPU_ACC, S_CPU_CAP, S_CPU_HOLD, S_HALTED, S_DIAG_ACC, S_DIAG_CAP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            act_q;
    logic                  cpu_active_raw, cpu_act_sync, cpu_start;
    logic                  cpu_lat, diag_lat, cap_cpu, cap_diag;
    logic [ADDR_WIDTH-1:0] cpu_addr_q, diag_addr_q;
    logic [DATA_WIDTH-1:0] cpu_wdata_q, diag_wdata_q;
    logic                  cpu_wr_q, diag_we_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, diag_rdata_q;
    logic                  diag_valid_q;
    logic [ADDR_WIDTH-1:0] win_start_q [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0] win_end_q   [NUM_REGIONS];
    logic                  hit_any;
    logic [RW-1:0]         hit_idx;
    logic [ADDR_WIDTH-1:0] hit_off;
    logic                  wp_block;
    logic                  mirror_we_q;
    logic [RW-1:0]         mirror_idx_q;
    logic [ADDR_WIDTH-1:0] mirror_offset_q;

    assign cpu_active_raw = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
    assign cpu_act_sync   = act_q[1];
    assign cpu_start      = act_q[1] & ~act_q[2];

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) act_q <= '0;
        else       act_q <= {act_q[1:0], cpu_active_raw};
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, SRAM port mux and CPU/diag handshake outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cpu_lat       = 1'b0;
        diag_lat      = 1'b0;
        cap_cpu       = 1'b0;
        cap_diag      = 1'b0;
        ram_addr      = cpu_addr_q;
        ram_wdata     = cpu_wdata_q;
        ram_cs        = 1'b0;
        ram_we        = 1'b0;
        cpu_wait_n    = 1'b0;
        cpu_data_oe   = 1'b0;
        diag_halt_ack = 1'b0;
        case (state_q)
            S_LOAD: begin
                ram_addr  = flash_addr;
                ram_wdata = flash_wdata;
                ram_cs    = flash_cs;
                ram_we    = flash_we;
                if (load_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                cpu_wait_n = 1'b1;
                // CPU has priority over a halt request arriving in the same cycle
                if (cpu_start) begin
                    cpu_lat = 1'b1;
                    state_d = S_CPU_ACC;
                end else if (diag_halt_req) begin
                    state_d = S_HALTED;
                end
            end
            S_CPU_ACC: begin
                ram_cs  = 1'b1;
                ram_we  = cpu_wr_q & ~wp_block;
                state_d = S_CPU_CAP;
            end
            S_CPU_CAP: begin
                cap_cpu     = ~cpu_wr_q;
                cpu_data_oe = ~cpu_wr_q;
                cnt_d       = CW'(WAIT_CYCLES);
                state_d     = S_CPU_HOLD;
            end
            S_CPU_HOLD: begin
                cpu_data_oe = ~cpu_wr_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cpu_wait_n = 1'b1;
                    if (!cpu_act_sync) state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                diag_halt_ack = 1'b1;
                if (!diag_halt_req) begin
                    state_d = S_IDLE;
                end else if (diag_req) begin
                    diag_lat = 1'b1;
                    state_d  = S_DIAG_ACC;
                end
            end
            S_DIAG_ACC: begin
                diag_halt_ack = 1'b1;
                ram_addr      = diag_addr_q;
                ram_wdata     = diag_wdata_q;
                ram_cs        = 1'b1;
                ram_we        = diag_we_q;
                state_d       = S_DIAG_CAP;
            end
            S_DIAG_CAP: begin
                diag_halt_ack = 1'b1;
                cap_diag      = 1'b1;
                // A request still held here starts the next access directly,
                // giving one diag access every two clocks
                if (diag_halt_req && diag_req) begin
                    diag_lat = 1'b1;
                    state_d  = S_DIAG_ACC;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_LOAD;
        endcase
        // Losing the image forces LOAD from anywhere, abandoning the access
        if (state_q != S_LOAD && !load_done) state_d = S_LOAD;
    end

    // Request latches and captured read data; wr is sampled from the pin once
    // the synchronised strobe has settled, so it is stable by then
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            cpu_wr_q     <= 1'b0;
            diag_addr_q  <= '0;
            diag_wdata_q <= '0;
            diag_we_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            diag_rdata_q <= '0;
            diag_valid_q <= 1'b0;
        end else begin
            if (cpu_lat) begin
                cpu_addr_q  <= cpu_addr;
                cpu_wdata_q <= cpu_wdata;
                cpu_wr_q    <= ~cpu_wr_n;
            end
            if (diag_lat) begin
                diag_addr_q  <= diag_addr;
                diag_wdata_q <= diag_wdata;
                diag_we_q    <= diag_we;
            end
            if (cap_cpu)  cpu_rdata_q  <= ram_rdata;
            if (cap_diag) diag_rdata_q <= ram_rdata;
            diag_valid_q <= cap_diag;
        end
    end

    // Window bounds registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                win_start_q[i] <= '0;
                win_end_q[i]   <= '0;
            end
        end else if (win_wr) begin
            win_start_q[win_sel] <= win_start;
            win_end_q[win_sel]   <= win_end;
        end
    end

`ifdef RAM_WRITE_PROTECT_EN
    logic win_ro_q [NUM_REGIONS];

    // Read-only flags per window
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) win_ro_q[i] <= 1'b0;
        end else if (win_wr) begin
            win_ro_q[win_sel] <= win_ro;
        end
    end

    // A CPU write touching any read-only window is suppressed
    always_comb begin
        wp_block = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (win_ro_q[i] && cpu_addr_q >= win_start_q[i] && cpu_addr_q < win_end_q[i])
                wp_block = 1'b1;
        end
    end
`else
    logic unused_win_ro;
    assign unused_win_ro = win_ro;
    assign wp_block      = 1'b0;
`endif

    // Lowest-index window containing the current SRAM address
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (ram_addr >= win_start_q[i] && ram_addr < win_end_q[i]) begin
                hit_any = 1'b1;
                hit_idx = RW'(i);
                hit_off = ram_addr - win_start_q[i];
            end
        end
    end

    // Mirror write notification, one clock behind the SRAM write
    always_ff @(posedge clk) begin
        if (reset) begin
            mirror_we_q     <= 1'b0;
            mirror_idx_q    <= '0;
            mirror_offset_q <= '0;
        end else if (state_q != S_LOAD && ram_we && hit_any) begin
            mirror_we_q     <= 1'b1;
            mirror_idx_q    <= hit_idx;
            mirror_offset_q <= hit_off;
        end else begin
            mirror_we_q <= 1'b0;
        end
    end

    assign cpu_rdata     = cpu_rdata_q;
    assign diag_rdata    = diag_rdata_q;
    assign diag_valid    = diag_valid_q;
    assign mirror_we     = mirror_we_q;
    assign mirror_idx    = mirror_idx_q;
    assign mirror_offset = mirror_offset_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - scoreboard bench for ram_bus_arbiter with behavioural SRAM
module tb_ram_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int WC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, load_done;
    logic [AW-1:0] flash_addr;
    logic [DW-1:0] flash_wdata;
    logic          flash_cs, flash_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_data_oe, cpu_wait_n;
    logic          diag_halt_req, diag_halt_ack;
    logic          diag_req, diag_we;
    logic [AW-1:0] diag_addr;
    logic [DW-1:0] diag_wdata;
    logic [DW-1:0] diag_rdata;
    logic          diag_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_cs, ram_we;
    logic [DW-1:0] ram_rdata;
    logic          win_wr;
    logic [1:0]    win_sel;
    logic [AW-1:0] win_start, win_end;
    logic          win_ro;
    logic          mirror_we;
    logic [1:0]    mirror_idx;
    logic [AW-1:0] mirror_offset;

    ram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGIONS(NR), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .load_done(load_done),
        .flash_addr(flash_addr), .flash_wdata(flash_wdata), .flash_cs(flash_cs), .flash_we(flash_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n),
        .cpu_wr_n(cpu_wr_n), .cpu_rdata(cpu_rdata), .cpu_data_oe(cpu_data_oe), .cpu_wait_n(cpu_wait_n),
        .diag_halt_req(diag_halt_req), .diag_halt_ack(diag_halt_ack), .diag_req(diag_req),
        .diag_we(diag_we), .diag_addr(diag_addr), .diag_wdata(diag_wdata), .diag_rdata(diag_rdata),
        .diag_valid(diag_valid), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .win_wr(win_wr), .win_sel(win_sel),
        .win_start(win_start), .win_end(win_end), .win_ro(win_ro), .mirror_we(mirror_we),
        .mirror_idx(mirror_idx), .mirror_offset(mirror_offset)
    );

    // Behavioural single-port SRAM, read data one clock after chip select
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: memory contents and window table as intended by the stimulus
    logic [DW-1:0] ref_mem [0:65535];
    logic [AW-1:0] ws [NR];
    logic [AW-1:0] we_ [NR];
    logic          wro [NR];

    logic [DW-1:0] rq[$];
    logic [DW-1:0] dq[$];
    logic [17:0]   mq[$];

    function automatic logic mir_hit(input logic [AW-1:0] a, output logic [1:0] idx, output logic [AW-1:0] off);
        mir_hit = 1'b0;
        idx = '0;
        off = '0;
        for (int i = 0; i < NR; i++) begin
            if (!mir_hit && ws[i] <= a && a < we_[i]) begin
                mir_hit = 1'b1;
                idx = 2'(i);
                off = a - ws[i];
            end
        end
    endfunction

    function automatic logic ro_hit(input logic [AW-1:0] a);
        ro_hit = 1'b0;
        for (int i = 0; i < NR; i++)
            if (wro[i] && ws[i] <= a && a < we_[i]) ro_hit = 1'b1;
    endfunction

    // Mirror monitor: pops the expected window hit and checks the one-clock lag
    logic        prev_we = 1'b0;
    logic [17:0] me;
    int          we_cnt = 0;
    always @(negedge clk) begin
        if (!reset && mirror_we) begin
            check("mirror_lag", prev_we, 1);
            if (mq.size() == 0) begin
                check("mirror_unexpected", 1, 0);
            end else begin
                me = mq.pop_front();
                check("mirror_idx", mirror_idx, me[17:16]);
                check("mirror_off", mirror_offset, me[15:0]);
            end
        end
        prev_we = ram_cs & ram_we & load_done;
        if (!reset && load_done && ram_cs && ram_we) we_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic prog_win(input int sel, input logic [AW-1:0] s, input logic [AW-1:0] e, input logic ro);
        @(negedge clk);
        win_wr = 1'b1; win_sel = 2'(sel); win_start = s; win_end = e; win_ro = ro;
        ws[sel] = s; we_[sel] = e; wro[sel] = ro;
        @(negedge clk);
        win_wr = 1'b0;
    endtask

    task automatic flash_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        flash_addr = a; flash_wdata = d; flash_cs = 1'b1; flash_we = 1'b1;
        ref_mem[a] = d;
    endtask

    task automatic cpu_cycle(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic halt_same);
        int n, low;
        logic ack_seen, blk;
        logic [1:0] mi;
        logic [AW-1:0] mo;
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_mreq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = ~wr;
        if (!wr) begin
            rq.push_back(ref_mem[a]);
        end else begin
`ifdef RAM_WRITE_PROTECT_EN
            blk = ro_hit(a);
`else
            blk = 1'b0;
`endif
            if (!blk) begin
                ref_mem[a] = d;
                if (mir_hit(a, mi, mo)) mq.push_back({mi, mo});
            end
        end
        repeat (2) @(negedge clk);
        if (halt_same) diag_halt_req = 1'b1;
        n = 0;
        while (cpu_wait_n && n < 8) begin @(negedge clk); n++; end
        low = 0;
        ack_seen = 1'b0;
        while (!cpu_wait_n && low < 20) begin
            ack_seen |= diag_halt_ack;
            @(negedge clk);
            low++;
        end
        check("cpu_wait_low", low, 2 + WC);
        if (halt_same) check("ack_during_cpu", ack_seen, 0);
        if (!wr) begin
            check("cpu_oe_hold", cpu_data_oe, 1);
            check("cpu_rdata", cpu_rdata, rq.pop_front());
        end else begin
            check("cpu_oe_write", cpu_data_oe, 0);
        end
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        repeat (4) @(negedge clk);
        check("cpu_oe_release", cpu_data_oe, 0);
    endtask

    task automatic diag_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        logic [1:0] mi;
        logic [AW-1:0] mo;
        @(negedge clk);
        diag_req = 1'b1; diag_we = wr; diag_addr = a; diag_wdata = d;
        if (!wr) begin
            dq.push_back(ref_mem[a]);
        end else begin
            ref_mem[a] = d;
            if (mir_hit(a, mi, mo)) mq.push_back({mi, mo});
        end
        @(negedge clk);
        diag_req = 1'b0;
        n = 1;
        while (!diag_valid && n < 10) begin @(negedge clk); n++; end
        check("diag_latency", n, 3);
        if (!wr) check("diag_rdata", diag_rdata, dq.pop_front());
        @(negedge clk);
        check("diag_valid_pulse", diag_valid, 0);
    endtask

    initial begin
        int n, vcnt, first, second, w0;
        reset = 1'b1; load_done = 1'b0;
        flash_addr = 16'h1234; flash_wdata = 8'h5A; flash_cs = 1'b1; flash_we = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        diag_halt_req = 1'b0; diag_req = 1'b0; diag_we = 1'b0; diag_addr = '0; diag_wdata = '0;
        win_wr = 1'b0; win_sel = '0; win_start = '0; win_end = '0; win_ro = 1'b0;
        for (int i = 0; i < NR; i++) begin ws[i] = '0; we_[i] = '0; wro[i] = 1'b0; end
        ref_mem[16'h1234] = 8'h5A;

        repeat (2) @(negedge clk);
        check("rst_ram_addr", ram_addr, 16'h1234);
        check("rst_ram_we", ram_we, 1);
        check("rst_ram_cs", ram_cs, 1);
        check("rst_wait_n", cpu_wait_n, 0);
        check("rst_oe", cpu_data_oe, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ack", diag_halt_ack, 0);
        check("rst_diag_valid", diag_valid, 0);
        check("rst_diag_rdata", diag_rdata, 0);
        check("rst_mirror_we", mirror_we, 0);
        check("rst_mirror_idx", mirror_idx, 0);
        check("rst_mirror_off", mirror_offset, 0);
        reset = 1'b0;

        flash_write(16'h0100, 8'hA5);
        flash_write(16'h0200, 8'h3C);
        @(negedge clk);
        flash_cs = 1'b0; flash_we = 1'b0; load_done = 1'b1;
        @(negedge clk);
        check("idle_wait_n", cpu_wait_n, 1);

        cpu_cycle(1'b0, 16'h0100, 8'h00, 1'b0);
        cpu_cycle(1'b0, 16'h0200, 8'h00, 1'b0);
        cpu_cycle(1'b0, 16'h1234, 8'h00, 1'b0);

        prog_win(1, 16'h8000, 16'h8800, 1'b0);
        cpu_cycle(1'b1, 16'h8010, 8'h42, 1'b0);
        cpu_cycle(1'b1, 16'h8800, 8'h43, 1'b0);
        prog_win(0, 16'h8000, 16'h8100, 1'b0);
        cpu_cycle(1'b1, 16'h8020, 8'h44, 1'b0);
        cpu_cycle(1'b0, 16'h8010, 8'h00, 1'b0);

        cpu_cycle(1'b0, 16'h0100, 8'h00, 1'b1);
        n = 0;
        while (!diag_halt_ack && n < 8) begin @(negedge clk); n++; end
        check("halt_ack_rise", diag_halt_ack, 1);
        check("halt_wait_n", cpu_wait_n, 0);

        diag_access(1'b0, 16'h0100, 8'h00);
        diag_access(1'b0, 16'h8020, 8'h00);

        @(negedge clk);
        diag_req = 1'b1; diag_we = 1'b0; diag_addr = 16'h0100; dq.push_back(ref_mem[16'h0100]);
        @(negedge clk);
        diag_addr = 16'h0200; dq.push_back(ref_mem[16'h0200]);
        repeat (2) @(negedge clk);
        vcnt = 0; first = -1; second = -1;
        for (int k = 0; k < 6; k++) begin
            if (diag_valid) begin
                if (vcnt == 0) first = k; else second = k;
                vcnt++;
                if (dq.size() > 0) check("diag_b2b_rdata", diag_rdata, dq.pop_front());
            end
            if (k == 0) diag_req = 1'b0;
            @(negedge clk);
        end
        check("diag_b2b_count", vcnt, 2);
        check("diag_b2b_spacing", second - first, 2);

        prog_win(2, 16'hC000, 16'hD000, 1'b1);
        w0 = we_cnt;
        diag_access(1'b1, 16'hC000, 8'h77);
        check("diag_wp_ram_we", we_cnt - w0, 1);

        @(negedge clk);
        diag_halt_req = 1'b0;
        @(negedge clk);
        check("release_ack", diag_halt_ack, 0);
        check("release_wait_n", cpu_wait_n, 1);

        w0 = we_cnt;
        cpu_cycle(1'b1, 16'hC000, 8'h11, 1'b0);
`ifdef RAM_WRITE_PROTECT_EN
        check("cpu_wp_ram_we", we_cnt - w0, 0);
`else
        check("cpu_wp_ram_we", we_cnt - w0, 1);
`endif

        @(negedge clk);
        diag_halt_req = 1'b1;
        @(negedge clk);
        check("halt_idle_ack", diag_halt_ack, 1);
        diag_access(1'b0, 16'hC000, 8'h00);
        @(negedge clk);
        diag_halt_req = 1'b0;
        repeat (2) @(negedge clk);

        @(negedge clk);
        cpu_addr = 16'h0200; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        n = 0;
        while (!cpu_data_oe && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        check("hold_wait_n", cpu_wait_n, 0);
        load_done = 1'b0; flash_addr = 16'h0ABC; flash_cs = 1'b1; flash_we = 1'b0;
        @(negedge clk);
        check("abort_wait_n", cpu_wait_n, 0);
        check("abort_ram_addr", ram_addr, 16'h0ABC);
        check("abort_ram_cs", ram_cs, 1);
        check("abort_ram_we", ram_we, 0);
        check("abort_oe", cpu_data_oe, 0);
        flash_cs = 1'b0;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        repeat (3) @(negedge clk);
        load_done = 1'b1;
        repeat (2) @(negedge clk);
        check("reload_wait_n", cpu_wait_n, 1);

        cpu_cycle(1'b0, 16'h0100, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        check("mirror_q_empty", mq.size(), 0);
        check("diag_q_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Parametrised arbiter between the flash loader, the Z80 CPU bus and the diagnostics port, all sharing the single-port image SRAM. It generates CPU wait states and runs the halt/ack handshake so diagnostics can reach RAM safely. It also holds `NUM_REGIONS` runtime-programmable mirror windows, generalising the fixed video-RAM window. It sits between the pin-level SB_IO buffers and `sram64k`.

## Interface
- `ADDR_WIDTH`, 16, address width of CPU, RAM and windows
- `DATA_WIDTH`, 8, data width
- `NUM_REGIONS`, 4, number of mirror windows (≥2, power of two); `RW = log2(NUM_REGIONS)`
- `WAIT_CYCLES`, 2, extra clocks `cpu_wait_n` is held low after read data is captured (0 allowed)

Ports:
- `clk` in 1: internal oscillator clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high
- `load_done` in 1: flash image load finished
- `flash_addr` in ADDR_WIDTH, `flash_wdata` in DATA_WIDTH, `flash_cs` in 1, `flash_we` in 1: loader RAM port
- `cpu_addr` in ADDR_WIDTH, `cpu_wdata` in DATA_WIDTH, `cpu_mreq_n`/`cpu_rd_n`/`cpu_wr_n` in 1: raw (asynchronous) Z80 bus
- `cpu_rdata` out DATA_WIDTH: registered read data; `cpu_data_oe` out 1: drive data pins
- `cpu_wait_n` out 1: Z80 WAIT, low = stall
- `diag_halt_req` in 1, `diag_halt_ack` out 1
- `diag_req` in 1, `diag_we` in 1, `diag_addr` in ADDR_WIDTH, `diag_wdata` in DATA_WIDTH
- `diag_rdata` out DATA_WIDTH, `diag_valid` out 1: one-cycle pulse
- `ram_addr` out ADDR_WIDTH, `ram_wdata` out DATA_WIDTH, `ram_cs` out 1, `ram_we` out 1, `ram_rdata` in DATA_WIDTH: SRAM, read data valid 1 clk after `ram_cs`
- `win_wr` in 1, `win_sel` in RW, `win_start`/`win_end` in ADDR_WIDTH, `win_ro` in 1: window programming
- `mirror_we` out 1, `mirror_idx` out RW, `mirror_offset` out ADDR_WIDTH

## Operation
- CPU strobes pass through a 2-flop synchroniser. `cpu_active = mreq & (rd | wr)`, all active-low inputs inverted. `cpu_start` is the rising edge of synchronised `cpu_active`.
- States:
  - LOAD: `ram_*` driven combinationally from `flash_*`. Exit to IDLE when `load_done`=1.
  - IDLE: on `cpu_start`, latch address, data and rd/wr, then go to CPU_ACC. Otherwise, if `diag_halt_req`, go to HALTED. If both occur in the same cycle, the CPU wins.
  - CPU_ACC: `ram_cs`=1 for 1 clk; `ram_we` = latched wr. Next: CPU_CAP.
  - CPU_CAP: `cpu_rdata <= ram_rdata` on reads; load wait counter with WAIT_CYCLES. Next: CPU_HOLD.
  - CPU_HOLD: decrement counter to 0. When counter is 0 and synchronised `cpu_active`=0, go to IDLE.
  - HALTED: `diag_halt_ack`=1. On `diag_req`, go to DIAG_ACC. When `diag_halt_req`=0, go to IDLE, and `diag_halt_ack` falls in the same cycle as the transition.
  - DIAG_ACC: `ram_cs`=1 for 1 clk with `diag_*`. Next: DIAG_CAP.
  - DIAG_CAP: `diag_rdata <= ram_rdata`, `diag_valid`=1, `diag_halt_ack` stays 1. Next: HALTED.
- `load_done` falling in any state: next state is LOAD and any in-flight access is abandoned.
- `cpu_wait_n` = 0 in LOAD, HALTED, DIAG_*, CPU_ACC, CPU_CAP, and in CPU_HOLD while counter ≠ 0. It is 1 otherwise.
- `cpu_data_oe` = 1 from CPU_CAP until the return to IDLE, for read cycles only.
- `diag_req` outside HALTED is ignored (no `diag_valid`).
- Windows:
  - `win_wr` writes start, end and ro into slot `win_sel`. Window i is hit when `start_i ≤ addr < end_i` (unsigned). `start ≥ end` means empty.
  - On any `ram_we`=1 outside LOAD, the lowest-index hit produces, next clk, `mirror_we`=1, `mirror_idx`=i, `mirror_offset`=addr−start_i (ADDR_WIDTH wrap).
  - No hit: `mirror_we`=0.
- Reset:
  - State LOAD.
  - Outputs: `cpu_wait_n`=0, `cpu_data_oe`=0, `cpu_rdata`=0, `diag_halt_ack`=0, `diag_valid`=0, `diag_rdata`=0, `mirror_we`=0, `mirror_idx`=0, `mirror_offset`=0.
  - All windows start=end=0, ro=0. Synchroniser flops cleared.
  - `ram_cs`/`ram_we` follow `flash_cs`/`flash_we` (LOAD pass-through).

## Timing
- CPU read: `cpu_start` → `ram_cs` +1 clk → `cpu_rdata` valid +2 → `cpu_wait_n` high +2+WAIT_CYCLES. Plus 2 clk synchroniser latency from the pin.
- Diag access: `diag_req` sampled in HALTED → `diag_valid` 2 clk later. Back-to-back `diag_req` gives one access per 2 clk.
- Halt latency: ≤1 clk from IDLE; otherwise after the current CPU cycle ends.
- Mirror outputs lag `ram_we` by exactly 1 clk.

## Configuration
- `RAM_WRITE_PROTECT_EN` defined:
  - CPU writes hitting any window with ro=1 force `ram_we`=0 and `mirror_we`=0. The cycle otherwise completes normally, including wait states.
  - Diag writes are never blocked.
- Not defined: `win_ro` is ignored and all windows are writable.

## Test plan
- Reset, `load_done`=0, `flash_cs`=`flash_we`=1, addr 0x1234 → `ram_addr`=0x1234, `ram_we`=1, `cpu_wait_n`=0.
- WAIT_CYCLES=2, CPU read 0x0100, RAM returns 0xA5 → `cpu_rdata`=0xA5; `cpu_wait_n` low for exactly 4 clk after `cpu_start`; `cpu_data_oe` drops after strobes release.
- Window 1 = [0x8000,0x8800), CPU write 0x8010 → next clk `mirror_we`=1, idx=1, offset=0x0010. Write to 0x8800 → no mirror. Overlapping window 0 = [0x8000,0x8100) → idx=0.
- `diag_halt_req` asserted in the same clk as `cpu_start` → CPU access completes first, `diag_halt_ack` rises only afterwards. Diag read 0x0100 → `diag_valid` pulse 2 clk later with 0xA5. Drop the request → ack falls and `cpu_wait_n`=1.
- `load_done` dropped during CPU_HOLD → next clk state LOAD, `cpu_wait_n`=0, `ram_*` follows `flash_*`.
- `RAM_WRITE_PROTECT_EN` set, window 2 ro=1 at [0xC000,0xD000), CPU write 0xC000 → `ram_we`=0, `mirror_we`=0. Diag write 0xC000 → `ram_we`=1.
